// File: rtl/store_load_buffer_if.sv
// store_load_buffer_if
//   Bundles the store/load request channels and the single data-memory port
//   of the store_load_buffer.
//   master : pipeline + memory side (drives requests and mem_rdata)
//   slave  : the store_load_buffer itself
//   Store channel : st_valid/st_ready, st_addr, st_size, st_data
//   Load channel  : ld_valid/ld_ready, ld_addr, ld_size, ld_unsigned,
//                   ld_rvalid, ld_rdata
//   Status        : misalign_err, empty
//   Memory port   : mem_read, mem_write, mem_addr, mem_wdata, mem_rdata
interface store_load_buffer_if #(
   parameter int XLEN = 64
);
   logic            st_valid;
   logic            st_ready;
   logic [XLEN-1:0] st_addr;
   logic [1:0]      st_size;
   logic [XLEN-1:0] st_data;

   logic            ld_valid;
   logic            ld_ready;
   logic [XLEN-1:0] ld_addr;
   logic [1:0]      ld_size;
   logic            ld_unsigned;
   logic            ld_rvalid;
   logic [XLEN-1:0] ld_rdata;

   logic            misalign_err;
   logic            empty;

   logic            mem_read;
   logic            mem_write;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output st_valid, st_addr, st_size, st_data,
      output ld_valid, ld_addr, ld_size, ld_unsigned,
      output mem_rdata,
      input  st_ready, ld_ready, ld_rvalid, ld_rdata,
      input  misalign_err, empty,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      input  st_valid, st_addr, st_size, st_data,
      input  ld_valid, ld_addr, ld_size, ld_unsigned,
      input  mem_rdata,
      output st_ready, ld_ready, ld_rvalid, ld_rdata,
      output misalign_err, empty,
      output mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/store_load_buffer.sv
// store_load_buffer
//   Memory-stage unit owning the single port of a byte-addressed 64-bit data
//   memory (combinational read, posedge write). Stores are queued in a small
//   FIFO and drained with a same-cycle read-modify-write, so sub-doubleword
//   stores work on a doubleword-write memory. Loads are size/alignment checked
//   and sign/zero extended; a load that hits a buffered doubleword stalls.
// Ports
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : store_load_buffer_if.slave (request channels + memory port)
module store_load_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input logic                clk,
   input logic                rst_n,
   store_load_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   // FIFO storage: doubleword-aligned address, byte mask, lane-shifted data.
   logic [XLEN-1:0] ent_addr [DEPTH];
   logic [7:0]      ent_mask [DEPTH];
   logic [XLEN-1:0] ent_data [DEPTH];
   logic [DEPTH-1:0] ent_valid;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;

   logic            full;
   logic            is_empty;
   logic            st_mis;
   logic            ld_mis;
   logic [XLEN-1:0] st_line;
   logic [XLEN-1:0] ld_line;
   logic            hazard;
   logic            load_go;
   logic            drain_go;
   logic            push;
   logic            st_take;
   logic [XLEN-1:0] head_lanes;
   logic [XLEN-1:0] ld_word;
   logic [XLEN-1:0] ld_ext;
   logic            sign;

   logic            ld_rvalid_q;
   logic [XLEN-1:0] ld_rdata_q;
   logic            misalign_q;

   // Misaligned when addr mod (1<<size) != 0.
   function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return lo[0];
         2'd2:    return |lo[1:0];
         default: return |lo;
      endcase
   endfunction

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] expand(input logic [7:0] m);
      logic [XLEN-1:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
      return r;
   endfunction

   assign full     = (count == (PW+1)'(DEPTH));
   assign is_empty = (count == '0);
   assign st_mis   = misaligned(bus.st_addr[2:0], bus.st_size);
   assign ld_mis   = misaligned(bus.ld_addr[2:0], bus.ld_size);
   assign st_line  = {bus.st_addr[XLEN-1:3], 3'b000};
   assign ld_line  = {bus.ld_addr[XLEN-1:3], 3'b000};

   // Only entries present at the start of the cycle count; a store pushed in
   // the same cycle is younger than the load and cannot hazard it.
   // NOTE: every always_comb output gets a default first, otherwise paths that
   // skip an assignment infer a latch.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_valid[i] && ent_addr[i] == ld_line) hazard = 1'b1;
   end

   // Arbitration: full forces a drain; otherwise a clean load wins; otherwise
   // drain whenever anything is buffered.
   assign load_go  = bus.ld_valid && !full && !hazard;
   assign drain_go = full || (!is_empty && !load_go);
   assign st_take  = bus.st_valid && !full;
   assign push     = st_take && !st_mis;

   assign head_lanes = expand(ent_mask[rd_ptr]);

   assign bus.st_ready  = !full;
   assign bus.ld_ready  = load_go;
   assign bus.empty     = is_empty;
   assign bus.mem_read  = drain_go || (load_go && !ld_mis);
   assign bus.mem_write = drain_go;
   assign bus.mem_addr  = drain_go ? ent_addr[rd_ptr] :
                          (load_go && !ld_mis) ? ld_line : '0;
   assign bus.mem_wdata = drain_go ? ((ent_data[rd_ptr] & head_lanes) |
                                      (bus.mem_rdata & ~head_lanes)) : '0;

   assign bus.ld_rvalid    = ld_rvalid_q;
   assign bus.ld_rdata     = ld_rdata_q;
   assign bus.misalign_err = misalign_q;

   // Pick the addressed bytes out of the doubleword and extend them.
   always_comb begin
      ld_word = bus.mem_rdata >> {bus.ld_addr[2:0], 3'b000};
      sign    = 1'b0;
      ld_ext  = ld_word;
      case (bus.ld_size)
         2'd0: begin
            sign   = !bus.ld_unsigned && ld_word[7];
            ld_ext = {{(XLEN-8){sign}}, ld_word[7:0]};
         end
         2'd1: begin
            sign   = !bus.ld_unsigned && ld_word[15];
            ld_ext = {{(XLEN-16){sign}}, ld_word[15:0]};
         end
         2'd2: begin
            sign   = !bus.ld_unsigned && ld_word[31];
            ld_ext = {{(XLEN-32){sign}}, ld_word[31:0]};
         end
         default: ld_ext = ld_word;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         ent_valid   <= '0;
         ld_rvalid_q <= 1'b0;
         ld_rdata_q  <= '0;
         misalign_q  <= 1'b0;
      end else begin
         if (drain_go) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         count       <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain_go};
         ld_rvalid_q <= load_go;
         if (load_go) ld_rdata_q <= ld_mis ? '0 : ld_ext;
         misalign_q  <= (load_go && ld_mis) || (st_take && st_mis);
      end
   end

   // NOTE: the payload arrays are not reset; ent_valid alone says which
   // entries are live, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= st_line;
         ent_mask[wr_ptr] <= size_mask(bus.st_size) << bus.st_addr[2:0];
         ent_data[wr_ptr] <= bus.st_data << {bus.st_addr[2:0], 3'b000};
      end
   end
endmodule

// File: tb/tb_store_load_buffer.sv
module tb_store_load_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_load_buffer_if #(.XLEN(64)) bus ();

   store_load_buffer #(.DEPTH(4), .XLEN(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Data memory attached to the port: 8 doublewords (byte addresses 0..63).
   logic [63:0] mem [8];
   assign bus.mem_rdata = mem[bus.mem_addr[5:3]];
   always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[5:3]] <= bus.mem_wdata;

   // Reference: program-order byte memory; a load sees every older store.
   logic [7:0] ref_mem [64];

   typedef struct {
      int          cyc;
      logic        rvalid;
      logic [63:0] rdata;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic st_acc, ld_acc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic is_mis(input logic [63:0] a, input logic [1:0] s);
      return (a % (64'd1 << s)) != 0;
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] s, input logic u);
      int n = 1 << s;
      logic [63:0] v = '0;
      if (is_mis(a, s)) return '0;
      for (int i = 0; i < n; i++) v |= 64'(ref_mem[(a + i) % 64]) << (8 * i);
      if (s != 2'd3 && !u && v[8*n-1]) v |= ~64'd0 << (8 * n);
      return v;
   endfunction

   // One clock cycle of stimulus; records handshakes into the reference.
   task automatic drive(input logic sv, input logic [63:0] sa, input logic [1:0] ss,
                        input logic [63:0] sd, input logic lv, input logic [63:0] la,
                        input logic [1:0] ls, input logic lu);
      exp_t e;
      @(negedge clk);
      bus.st_valid = sv; bus.st_addr = sa; bus.st_size = ss; bus.st_data = sd;
      bus.ld_valid = lv; bus.ld_addr = la; bus.ld_size = ls; bus.ld_unsigned = lu;
      #1;
      st_acc = sv && bus.st_ready;
      ld_acc = lv && bus.ld_ready;
      if (bus.mem_read) check("mem_addr_aligned", 64'(bus.mem_addr[2:0]), 64'd0);
      if (ld_acc) begin
         e.cyc = cyc + 1; e.rvalid = 1'b1; e.rdata = ref_load(la, ls, lu); e.err = is_mis(la, ls);
         exp_q.push_back(e);
      end
      if (st_acc) begin
         if (is_mis(sa, ss)) begin
            if (ld_acc) exp_q[exp_q.size()-1].err = 1'b1;
            else begin
               e.cyc = cyc + 1; e.rvalid = 1'b0; e.rdata = '0; e.err = 1'b1;
               exp_q.push_back(e);
            end
         end else begin
            for (int i = 0; i < (1 << ss); i++) ref_mem[(sa + i) % 64] = sd[8*i +: 8];
         end
      end
   endtask

   task automatic idle();
      drive(1'b0, '0, 2'd0, '0, 1'b0, '0, 2'd0, 1'b0);
   endtask

   task automatic do_load(input logic [63:0] a, input logic [1:0] s, input logic u);
      int n = 0;
      do begin
         drive(1'b0, '0, 2'd0, '0, 1'b1, a, s, u);
         n++;
      end while (!ld_acc && n < 20);
      check("load_accepted", 64'(ld_acc), 64'd1);
   endtask

   task automatic do_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
      int n = 0;
      do begin
         drive(1'b1, a, s, d, 1'b0, '0, 2'd0, 1'b0);
         n++;
      end while (!st_acc && n < 20);
      check("store_accepted", 64'(st_acc), 64'd1);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (!bus.empty && n < 20) begin
         idle();
         n++;
      end
      check("drain_to_empty", 64'(bus.empty), 64'd1);
   endtask

   // Monitor: every response pulse must match the oldest expectation in time.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.ld_rvalid || bus.misalign_err) begin
            if (exp_q.size() == 0) begin
               check("spurious_response", {bus.ld_rvalid, bus.misalign_err}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("resp_cycle", 64'(cyc), 64'(e.cyc));
               check("resp_rvalid", 64'(bus.ld_rvalid), 64'(e.rvalid));
               if (e.rvalid) check("resp_rdata", bus.ld_rdata, e.rdata);
               check("resp_misalign", 64'(bus.misalign_err), 64'(e.err));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("resp_missing", 64'd0, 64'd1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, d, w;
      logic [1:0]  s;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      bus.st_valid = 0; bus.st_addr = '0; bus.st_size = '0; bus.st_data = '0;
      bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_size = '0; bus.ld_unsigned = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_st_ready", 64'(bus.st_ready), 64'd1);
      check("rst_empty", 64'(bus.empty), 64'd1);
      check("rst_mem_read", 64'(bus.mem_read), 64'd0);
      check("rst_mem_write", 64'(bus.mem_write), 64'd0);
      check("rst_mem_addr", bus.mem_addr, 64'd0);
      check("rst_mem_wdata", bus.mem_wdata, 64'd0);
      check("rst_ld_rvalid", 64'(bus.ld_rvalid), 64'd0);
      check("rst_ld_rdata", bus.ld_rdata, 64'd0);
      check("rst_misalign", 64'(bus.misalign_err), 64'd0);
      rst_n = 1'b1;

      // Reset mid-operation: three stores held in the buffer by a steady load
      drive(1'b0, '0, 2'd0, '0, 1'b1, 64'd56, 2'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'(8 * i), 2'd3, 64'hA5A5_0000_0000_0001 + 64'(i), 1'b1, 64'd56, 2'd3, 1'b0);
         check("hold_no_drain", 64'(bus.mem_write), 64'd0);
      end
      idle();
      check("pre_rst_empty", 64'(bus.empty), 64'd0);
      check("pre_rst_drain", 64'(bus.mem_write), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_empty", 64'(bus.empty), 64'd1);
      check("async_rst_st_ready", 64'(bus.st_ready), 64'd1);
      check("async_rst_mem_write", 64'(bus.mem_write), 64'd0);
      check("async_rst_mem_read", 64'(bus.mem_read), 64'd0);
      exp_q.delete();
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;   // discarded stores never landed
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) do_load(64'(8 * i), 2'd3, 1'b0);

      // Doubleword store then load
      do_store(64'd8, 2'd3, 64'h1122_3344_5566_7788);
      idle();
      check("sd_mem_write", 64'(bus.mem_write), 64'd1);
      check("sd_mem_addr", bus.mem_addr, 64'd8);
      check("sd_mem_wdata", bus.mem_wdata, 64'h1122_3344_5566_7788);
      do_load(64'd8, 2'd3, 1'b0);

      // Byte store, signed and unsigned byte loads
      do_store(64'd3, 2'd0, 64'hAB);
      idle();
      check("sb_mem_write", 64'(bus.mem_write), 64'd1);
      check("sb_mem_addr", bus.mem_addr, 64'd0);
      check("sb_mem_wdata", bus.mem_wdata, 64'h0000_0000_AB00_0000);
      do_load(64'd3, 2'd0, 1'b0);
      do_load(64'd3, 2'd0, 1'b1);

      // Hazard stall
      wait_empty();
      do_store(64'd16, 2'd2, 64'hDEAD_BEEF);
      drive(1'b0, '0, 2'd0, '0, 1'b1, 64'd20, 2'd2, 1'b1);
      check("hazard_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("hazard_drain_addr", bus.mem_addr, 64'd16);
      check("hazard_drain_write", 64'(bus.mem_write), 64'd1);
      do_load(64'd20, 2'd2, 1'b1);
      do_load(64'd16, 2'd2, 1'b1);
      do_load(64'd16, 2'd2, 1'b0);

      // Full priority
      wait_empty();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'(8 * i), 2'd3, 64'hC0DE_0000_0000_0000 + 64'(i), 1'b1, 64'd56, 2'd3, 1'b1);
         check("fill_st_ready", 64'(bus.st_ready), 64'd1);
         check("fill_ld_ready", 64'(bus.ld_ready), 64'd1);
         check("fill_no_drain", 64'(bus.mem_write), 64'd0);
      end
      drive(1'b1, 64'd32, 2'd3, 64'h1234, 1'b1, 64'd56, 2'd3, 1'b0);
      check("full_st_ready", 64'(bus.st_ready), 64'd0);
      check("full_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("full_drain_write", 64'(bus.mem_write), 64'd1);
      check("full_drain_addr", bus.mem_addr, 64'd0);
      drive(1'b1, 64'd32, 2'd3, 64'h1234, 1'b1, 64'd56, 2'd3, 1'b0);
      check("after_pop_st_ready", 64'(bus.st_ready), 64'd1);
      check("after_pop_ld_ready", 64'(bus.ld_ready), 64'd1);
      wait_empty();

      // Misaligned load and store
      drive(1'b0, '0, 2'd0, '0, 1'b1, 64'd5, 2'd1, 1'b0);
      check("mis_ld_ready", 64'(bus.ld_ready), 64'd1);
      check("mis_ld_mem_read", 64'(bus.mem_read), 64'd0);
      check("mis_ld_mem_write", 64'(bus.mem_write), 64'd0);
      drive(1'b1, 64'd6, 2'd2, 64'h5555_5555, 1'b0, '0, 2'd0, 1'b0);
      check("mis_st_ready", 64'(bus.st_ready), 64'd1);
      idle();
      check("mis_st_not_queued", 64'(bus.empty), 64'd1);

      // Randomized traffic against the reference
      for (int k = 0; k < 500; k++) begin
         s = 2'($urandom_range(0, 3));
         a = 64'($urandom_range(0, 63));
         if ($urandom_range(0, 99) < 85) a &= ~((64'd1 << s) - 1);
         d = {$urandom, $urandom};
         w = 64'($urandom_range(0, 63));
         if ($urandom_range(0, 99) < 85) w &= ~64'(7);
         drive($urandom_range(0, 1) == 1, a, s, d,
               $urandom_range(0, 2) != 0, w, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      end

      // Final image must equal program-order memory
      wait_empty();
      repeat (3) idle();
      for (int i = 0; i < 8; i++) begin
         w = '0;
         for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_mem[8*i + b];
         check("final_mem", mem[i], w);
      end
      check("responses_outstanding", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
